// File: rtl/exu_pkg.sv
// Shared types for the execute operand-select stage:
// special-instruction codes, the operand bundle and skid FSM states.
package exu_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] SPEC_NONE  = 3'd0;
  localparam logic [2:0] SPEC_JAL   = 3'd1;
  localparam logic [2:0] SPEC_JALR  = 3'd2;
  localparam logic [2:0] SPEC_AUIPC = 3'd3;
  localparam logic [2:0] SPEC_LUI   = 3'd4;
  localparam logic [2:0] SPEC_STORE = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] alu_A;
    logic [XLEN-1:0] alu_B;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

endpackage

// File: rtl/exu_bypass_mux.sv
// Priority forward of one source operand from the writeback bypass ports.
// Lowest-numbered matching port wins; index 0 is never forwarded.
module exu_bypass_mux #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BYP    = 2,
  parameter int REG_AW     = 5
) (
  input  logic [REG_AW-1:0]           src_idx,
  input  logic [DATA_WIDTH-1:0]       rf_data,
  input  logic [NUM_BYP-1:0]          byp_valid,
  input  logic [NUM_BYP*REG_AW-1:0]   byp_idx,
  input  logic [NUM_BYP*DATA_WIDTH-1:0] byp_data,
  output logic [DATA_WIDTH-1:0]       data
);

  // Walk high to low so the lowest matching port is written last.
  always_comb begin
    data = rf_data;
    for (int k = NUM_BYP - 1; k >= 0; k--) begin
      if (byp_valid[k] &&
          byp_idx[k*REG_AW +: REG_AW] == src_idx &&
          src_idx != '0) begin
        data = byp_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/exu_operand_stage.sv
// Registered operand select for the RV64I execute path:
// bypass resolution, special-op operand rules, two-entry skid buffer.
module exu_operand_stage
  import exu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BYP    = 2,
  parameter int REG_AW     = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          ers1_i,
  input  logic                          ers2_i,
  input  logic [2:0]                    specinst_i,
  input  logic                          word_i,
  input  logic [REG_AW-1:0]             rs1_idx_i,
  input  logic [REG_AW-1:0]             rs2_idx_i,
  input  logic [DATA_WIDTH-1:0]         rs1_i,
  input  logic [DATA_WIDTH-1:0]         rs2_i,
  input  logic [DATA_WIDTH-1:0]         pc_i,
  input  logic [DATA_WIDTH-1:0]         imme_i,
  input  logic [NUM_BYP-1:0]            byp_valid_i,
  input  logic [NUM_BYP*REG_AW-1:0]     byp_idx_i,
  input  logic [NUM_BYP*DATA_WIDTH-1:0] byp_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         alu_A_o,
  output logic [DATA_WIDTH-1:0]         alu_B_o,
  output logic [DATA_WIDTH-1:0]         store_data_o,
  output logic [DATA_WIDTH-1:0]         pc_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_A;
    logic [DATA_WIDTH-1:0] alu_B;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] pc;
  } ent_t;

  state_t state, state_nx;
  ent_t   head, tail, nw;
  logic   [DATA_WIDTH-1:0] f1, f2;
  logic   accept, pop;
  logic   ld_head_new, ld_head_tail, ld_tail;

  exu_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_BYP(NUM_BYP), .REG_AW(REG_AW)
  ) u_byp1 (
    .src_idx(rs1_idx_i), .rf_data(rs1_i),
    .byp_valid(byp_valid_i), .byp_idx(byp_idx_i),
    .byp_data(byp_data_i), .data(f1)
  );

  exu_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_BYP(NUM_BYP), .REG_AW(REG_AW)
  ) u_byp2 (
    .src_idx(rs2_idx_i), .rf_data(rs2_i),
    .byp_valid(byp_valid_i), .byp_idx(byp_idx_i),
    .byp_data(byp_data_i), .data(f2)
  );

  always_comb begin
    logic is_st;
    logic is_j;
    is_st = (specinst_i == SPEC_STORE);
    is_j  = (specinst_i == SPEC_JAL) || (specinst_i == SPEC_JALR);
    nw    = '0;
    nw.pc = pc_i;
    if (ers1_i)
      nw.alu_A = f1;
    else if (is_j || specinst_i == SPEC_AUIPC)
      nw.alu_A = pc_i;
    if (ers2_i && is_st)
      nw.alu_B = imme_i;
    else if (ers2_i)
      nw.alu_B = f2;
    else if (specinst_i == SPEC_LUI)
      nw.alu_B = '0;
    else if (is_j)
      nw.alu_B = DATA_WIDTH'(4);
    else
      nw.alu_B = imme_i;
    if (ers2_i && is_st)
      nw.store_data = f2;
    if (word_i) begin
      nw.alu_A = {{(DATA_WIDTH-32){nw.alu_A[31]}}, nw.alu_A[31:0]};
      nw.alu_B = {{(DATA_WIDTH-32){nw.alu_B[31]}}, nw.alu_B[31:0]};
    end
  end

  assign in_ready_o  = (state != ST_TWO) & ~rst & ~flush_i;
  assign out_valid_o = (state != ST_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    ld_head_new  = 1'b0;
    ld_head_tail = 1'b0;
    ld_tail      = 1'b0;
    unique case (state)
      ST_EMPTY: if (accept) begin
        state_nx    = ST_ONE;
        ld_head_new = 1'b1;
      end
      ST_ONE: begin
        if (accept && pop) begin
          ld_head_new = 1'b1;
        end else if (accept) begin
          state_nx = ST_TWO;
          ld_tail  = 1'b1;
        end else if (pop) begin
          state_nx = ST_EMPTY;
        end
      end
      ST_TWO: if (pop) begin
        state_nx     = ST_ONE;
        ld_head_tail = 1'b1;
      end
      default: state_nx = ST_EMPTY;
    endcase
    // Flush drops everything, including an entry arriving this cycle.
    if (flush_i) begin
      state_nx     = ST_EMPTY;
      ld_head_new  = 1'b0;
      ld_head_tail = 1'b0;
      ld_tail      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (ld_head_new)  head <= nw;
      if (ld_head_tail) head <= tail;
      if (ld_tail)      tail <= nw;
    end
  end

  assign alu_A_o      = head.alu_A;
  assign alu_B_o      = head.alu_B;
  assign store_data_o = head.store_data;
  assign pc_o         = head.pc;

endmodule

// File: tb/tb_exu_operand_stage.sv
// Scoreboard bench for exu_operand_stage: directed operand cases,
// backpressure, flush, reset, then randomized traffic.
module tb_exu_operand_stage;

  localparam int DW = 64;
  localparam int NB = 2;
  localparam int AW = 5;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] sd;
    logic [DW-1:0] pc;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic flush_i = 0;
  logic in_valid_i = 0;
  logic in_ready_o;
  logic ers1_i = 0, ers2_i = 0, word_i = 0;
  logic [2:0] specinst_i = 0;
  logic [AW-1:0] rs1_idx_i = 0, rs2_idx_i = 0;
  logic [DW-1:0] rs1_i = 0, rs2_i = 0, pc_i = 0, imme_i = 0;
  logic [NB-1:0] byp_valid_i = 0;
  logic [NB*AW-1:0] byp_idx_i = 0;
  logic [NB*DW-1:0] byp_data_i = 0;
  logic out_valid_o;
  logic out_ready_i = 0;
  logic [DW-1:0] alu_A_o, alu_B_o, store_data_o, pc_o;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  exu_operand_stage #(.DATA_WIDTH(DW), .NUM_BYP(NB), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ers1_i(ers1_i), .ers2_i(ers2_i), .specinst_i(specinst_i),
    .word_i(word_i), .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .pc_i(pc_i), .imme_i(imme_i),
    .byp_valid_i(byp_valid_i), .byp_idx_i(byp_idx_i),
    .byp_data_i(byp_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .alu_A_o(alu_A_o), .alu_B_o(alu_B_o),
    .store_data_o(store_data_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fwd(input logic [AW-1:0] idx,
                                        input logic [DW-1:0] rf);
    if (idx == 0) return rf;
    for (int k = 0; k < NB; k++)
      if (byp_valid_i[k] && byp_idx_i[k*AW +: AW] == idx)
        return byp_data_i[k*DW +: DW];
    return rf;
  endfunction

  function automatic logic [DW-1:0] sx32(input logic [DW-1:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic st;
    st = (specinst_i == 3'd5);
    e.pc = pc_i;
    if (ers1_i) e.a = fwd(rs1_idx_i, rs1_i);
    else if (specinst_i inside {3'd1, 3'd2, 3'd3}) e.a = pc_i;
    else e.a = 0;
    if (ers2_i && st) e.b = imme_i;
    else if (ers2_i) e.b = fwd(rs2_idx_i, rs2_i);
    else if (specinst_i == 3'd4) e.b = 0;
    else if (specinst_i inside {3'd1, 3'd2}) e.b = 64'd4;
    else e.b = imme_i;
    e.sd = (ers2_i && st) ? fwd(rs2_idx_i, rs2_i) : 64'd0;
    if (word_i) begin
      e.a = sx32(e.a);
      e.b = sx32(e.b);
    end
    return e;
  endfunction

  // Monitor: retire the head on a pop, then record any new acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush_i) begin
      exp_q.delete();
    end else begin
      if (out_valid_o && out_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got A=%h with empty scoreboard", alu_A_o);
        end else begin
          e = exp_q.pop_front();
          if (alu_A_o !== e.a || alu_B_o !== e.b ||
              store_data_o !== e.sd || pc_o !== e.pc) begin
            errors++;
            $display("FAIL sb_entry: got A=%h B=%h SD=%h PC=%h exp A=%h B=%h SD=%h PC=%h",
                     alu_A_o, alu_B_o, store_data_o, pc_o, e.a, e.b, e.sd, e.pc);
          end
        end
      end
      if (in_valid_i && in_ready_o) exp_q.push_back(model());
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h exp %h", name, act, req);
    end
  endtask

  task automatic set_op(input logic e1, input logic e2, input logic [2:0] sp,
                        input logic w, input logic [AW-1:0] i1,
                        input logic [AW-1:0] i2, input logic [DW-1:0] r1,
                        input logic [DW-1:0] r2, input logic [DW-1:0] pc,
                        input logic [DW-1:0] im);
    ers1_i = e1; ers2_i = e2; specinst_i = sp; word_i = w;
    rs1_idx_i = i1; rs2_idx_i = i2; rs1_i = r1; rs2_i = r2;
    pc_i = pc; imme_i = im; byp_valid_i = 0;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push_one();
    int n = 0;
    in_valid_i = 1;
    @(negedge clk);
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready_o=%b exp 1", in_ready_o);
    end
    @(posedge clk); #1;
    in_valid_i = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_o), 0);
    chk("rst_in_ready", 64'(in_ready_o), 0);
    chk("rst_alu_A", alu_A_o, 0);
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready_o), 1);
    step();
    out_ready_i = 1;

    set_op(1, 1, 0, 0, 1, 2, 5, 7, 0, 0);
    push_one(); @(negedge clk);
    chk("add_A", alu_A_o, 5);
    chk("add_B", alu_B_o, 7);
    step();

    set_op(0, 0, 1, 0, 0, 0, 0, 0, 64'h1000, 64'h40);
    push_one(); @(negedge clk);
    chk("jal_A", alu_A_o, 64'h1000);
    chk("jal_B", alu_B_o, 4);
    step();

    set_op(0, 0, 4, 0, 0, 0, 0, 0, 64'h80, 64'hABCD000);
    push_one(); @(negedge clk);
    chk("lui_A", alu_A_o, 0);
    chk("lui_B", alu_B_o, 0);
    step();

    set_op(1, 0, 0, 0, 3, 0, 64'h99, 0, 0, 0);
    byp_valid_i = 2'b11;
    byp_idx_i = {5'd3, 5'd3};
    byp_data_i = {64'h22, 64'h11};
    push_one(); @(negedge clk);
    chk("byp_priority", alu_A_o, 64'h11);
    step();

    set_op(1, 0, 0, 0, 0, 0, 64'h55, 0, 0, 0);
    byp_valid_i = 2'b01;
    byp_idx_i = {5'd0, 5'd0};
    byp_data_i = {64'h22, 64'h11};
    push_one(); @(negedge clk);
    chk("byp_x0", alu_A_o, 64'h55);
    step();

    set_op(1, 1, 5, 0, 1, 6, 64'h2000, 64'h1, 0, 8);
    byp_valid_i = 2'b10;
    byp_idx_i = {5'd6, 5'd0};
    byp_data_i = {64'hDEAD, 64'h0};
    push_one(); @(negedge clk);
    chk("st_A", alu_A_o, 64'h2000);
    chk("st_B", alu_B_o, 8);
    chk("st_data", store_data_o, 64'hDEAD);
    step();

    set_op(1, 0, 0, 1, 1, 0, 64'h0000_0000_8000_0001, 0, 0, 0);
    push_one(); @(negedge clk);
    chk("word_A", alu_A_o, 64'hFFFF_FFFF_8000_0001);
    step();

    // Backpressure: two held, third refused, then in-order drain.
    out_ready_i = 0;
    set_op(1, 1, 0, 0, 1, 2, 64'hA1, 64'hB1, 0, 0); push_one();
    set_op(1, 1, 0, 0, 1, 2, 64'hA2, 64'hB2, 0, 0); push_one();
    set_op(1, 1, 0, 0, 1, 2, 64'hA3, 64'hB3, 0, 0);
    in_valid_i = 1;
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready_o), 0);
    chk("hold_A", alu_A_o, 64'hA1);
    step();
    in_valid_i = 0;
    out_ready_i = 1;
    @(negedge clk);
    chk("drain1_valid", 64'(out_valid_o), 1);
    chk("drain1_A", alu_A_o, 64'hA1);
    @(negedge clk);
    chk("drain2_valid", 64'(out_valid_o), 1);
    chk("drain2_A", alu_A_o, 64'hA2);
    @(negedge clk);
    chk("drain_empty", 64'(out_valid_o), 0);
    step();

    out_ready_i = 0;
    push_one(); push_one();
    flush_i = 1;
    step();
    flush_i = 0;
    @(negedge clk);
    chk("flush_valid", 64'(out_valid_o), 0);
    step();

    push_one(); push_one();
    rst = 1;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid_o), 0);
    chk("midrst_in_ready", 64'(in_ready_o), 0);
    chk("midrst_A", alu_A_o, 0);
    chk("midrst_B", alu_B_o, 0);
    chk("midrst_SD", store_data_o, 0);
    chk("midrst_PC", pc_o, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready_o), 1);
    chk("rel_valid", 64'(out_valid_o), 0);
    step();

    for (int i = 0; i < 400; i++) begin
      ers1_i = 1'($urandom);
      ers2_i = 1'($urandom);
      specinst_i = 3'($urandom_range(0, 5));
      word_i = ($urandom_range(0, 3) == 0);
      rs1_idx_i = 5'($urandom_range(0, 3));
      rs2_idx_i = 5'($urandom_range(0, 3));
      rs1_i = {$urandom, $urandom};
      rs2_i = {$urandom, $urandom};
      pc_i = {$urandom, $urandom};
      imme_i = {$urandom, $urandom};
      byp_valid_i = 2'($urandom);
      byp_idx_i = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      byp_data_i = {$urandom, $urandom, $urandom, $urandom};
      in_valid_i = 1'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid_i = 0;
    flush_i = 0;
    out_ready_i = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exu_operand_stage.md
# exu_operand_stage

Registered operand-select stage for the RV64I execute path. Resolves rs1/rs2 against writeback bypass ports, applies the special-instruction operand rules, and presents ALU operands plus store data through a two-entry skid buffer with valid/ready handshake, flush and RV64 word-op sign extension. Sits between decode/register-read and the ALU.

## Interface
- DATA_WIDTH, 64, operand/PC width
- NUM_BYP, 2, number of bypass (forwarding) ports, ≥1
- REG_AW, 5, register index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  discard all held and incoming entries
- in_valid_i / in_ready_o  in/out  1  upstream handshake
- ers1_i, ers2_i  in  1  rs1/rs2 used as source
- specinst_i  in  3  0 none, 1 JAL, 2 JALR, 3 AUIPC, 4 LUI, 5 STORE
- word_i  in  1  RV64 W-op: sign-extend operands from bit 31
- rs1_idx_i, rs2_idx_i  in  REG_AW  source indices
- rs1_i, rs2_i, pc_i, imme_i  in  DATA_WIDTH  register-file data, PC, immediate
- byp_valid_i  in  NUM_BYP  bypass port valid
- byp_idx_i  in  NUM_BYP*REG_AW  bypass destination indices, port k at [k*REG_AW +: REG_AW]
- byp_data_i  in  NUM_BYP*DATA_WIDTH  bypass data, packed likewise
- out_valid_o / out_ready_i  out/in  1  downstream handshake
- alu_A_o, alu_B_o, store_data_o, pc_o  out  DATA_WIDTH  head-entry operands and PC

## Operation
- Forwarding per source: first port k (lowest index) with byp_valid_i[k] and byp_idx==src_idx and src_idx!=0 supplies data; else rs*_i. Index 0 never forwarded. Applied only in the accept cycle.
- alu_A: ers1 → fwd rs1; else JAL/JALR/AUIPC → pc_i; else 0.
- alu_B: ers2 & STORE → imme_i; ers2 → fwd rs2; LUI → 0; JAL/JALR → 4; else imme_i.
- store_data: fwd rs2 when ers2 & STORE, else 0.
- word_i=1: alu_A and alu_B replaced by sign-extension of bits [31:0]; store_data, pc untouched.
- Skid FSM, states EMPTY, ONE, TWO; accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → TWO; pop & !accept → EMPTY; both → ONE, new entry becomes head.
  - TWO: pop → ONE, tail becomes head; no accept possible.
- in_ready_o = (state != TWO) & !rst & !flush_i; out_valid_o = (state != EMPTY).
- flush_i: next edge state → EMPTY regardless of accept/pop; incoming entry dropped.

## Timing
- Latency 1: entry accepted at edge N visible on outputs after edge N; out_valid_o rises then.
- Full throughput in steady state with out_ready_i held high (ONE state, accept+pop each cycle).
- in_ready_o depends only on registered state, rst, flush_i; no combinational path from out_ready_i.
- Outputs hold stable while out_valid_o & !out_ready_i.
- Reset: state EMPTY; out_valid_o 0; alu_A_o, alu_B_o, store_data_o, pc_o 0; in_ready_o 0 while rst high, 1 the cycle after deassertion. Reset mid-transfer discards all entries.
- Bypass/flush same cycle: flush wins.

## Structure
- exu_pkg: specinst encoding constants (JAL=1 … STORE=5), entry struct {alu_A, alu_B, store_data, pc}, FSM state enum.
- Sub-module exu_bypass_mux (priority forward of one source), instantiated twice.

## Test plan
- Reset: assert rst mid-stream with two entries held → out_valid_o 0, all outputs 0, in_ready_o 1 one cycle after release.
- ADD: ers1=ers2=1, rs1_i=5, rs2_i=7, no bypass → alu_A=5, alu_B=7 next cycle; JAL pc_i=0x1000 → alu_A=0x1000, alu_B=4; LUI imme=0xABCD000 → alu_A=0, alu_B=0.
- Bypass priority: rs1_idx=3, ports 0 and 1 both idx 3 data 0x11/0x22 → alu_A=0x11; rs1_idx=0 with port idx 0 → alu_A=rs1_i.
- STORE: ers1=ers2=1, rs1_i=0x2000, rs2 forwarded 0xDEAD, imme=8 → alu_A=0x2000, alu_B=8, store_data=0xDEAD.
- Word op: rs1_i=0x0000_0000_8000_0001, word_i=1 → alu_A=0xFFFF_FFFF_8000_0001.
- Backpressure: out_ready_i=0, push 3 entries → two held, in_ready_o 0 on third; release → entries drain in order, one per cycle; flush with TWO → out_valid_o 0 next cycle.
